// File: rtl/butterfly_sequencer_pkg.sv
// rtl/butterfly_sequencer_pkg.sv - shared types and constants for the butterfly sequencer
// Holds the sequencer FSM state type, the complex-word field boundaries
// ({real[63:32], imag[31:0]}) and the per-component scaling helper.
package butterfly_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } seq_state_t;

  localparam int REAL_MSB = 63;
  localparam int IMAG_MSB = 31;

  // Arithmetic shift right by one on each 32-bit component independently,
  // so the sign of the imaginary part never leaks into the real part.
  function automatic logic [REAL_MSB:0] scale_word(input logic [REAL_MSB:0] w);
    logic signed [REAL_MSB-IMAG_MSB-1:0] re;
    logic signed [IMAG_MSB:0]            im;
    re = w[REAL_MSB:IMAG_MSB+1];
    im = w[IMAG_MSB:0];
    return {re >>> 1, im >>> 1};
  endfunction

endpackage

// File: rtl/butterfly_sequencer_if.sv
// rtl/butterfly_sequencer_if.sv - control, memory, twiddle and butterfly bus of the sequencer
// Ports (all carried as interface signals):
//   start/busy/done                     run control
//   rd_en, rd_addr_a/b, rd_data_a/b     data memory read (1-cycle latency)
//   tw_addr, tw_data                    twiddle ROM (1-cycle latency)
//   bf_a, bf_b, bf_tw, bf_a_res/b_res   butterfly operands and results
//   wr_en, wr_addr_a/b, wr_data_a/b     data memory write-back
// master = sequencer side, slave = memory/butterfly/controller side.
interface butterfly_sequencer_if #(
  parameter int LOG2N = 3
);
  import butterfly_sequencer_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [LOG2N-1:0]     rd_addr_a;
  logic [LOG2N-1:0]     rd_addr_b;
  logic [REAL_MSB:0]    rd_data_a;
  logic [REAL_MSB:0]    rd_data_b;
  logic [LOG2N-2:0]     tw_addr;
  logic [IMAG_MSB:0]    tw_data;
  logic [REAL_MSB:0]    bf_a;
  logic [REAL_MSB:0]    bf_b;
  logic [IMAG_MSB:0]    bf_tw;
  logic [REAL_MSB:0]    bf_a_res;
  logic [REAL_MSB:0]    bf_b_res;
  logic                 wr_en;
  logic [LOG2N-1:0]     wr_addr_a;
  logic [LOG2N-1:0]     wr_addr_b;
  logic [REAL_MSB:0]    wr_data_a;
  logic [REAL_MSB:0]    wr_data_b;

  modport master (
    input  start, rd_data_a, rd_data_b, tw_data, bf_a_res, bf_b_res,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_a, bf_b, bf_tw, wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

  modport slave (
    output start, rd_data_a, rd_data_b, tw_data, bf_a_res, bf_b_res,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_a, bf_b, bf_tw, wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
  );

endinterface

// File: rtl/seq_tag_delay.sv
// rtl/seq_tag_delay.sv - fixed-depth shift register for read tags, async clear
// Ports: clk, rst (async, active-high, clears every stage),
//        din [WIDTH] in, dout [WIDTH] = din delayed by DEPTH cycles.
module seq_tag_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/butterfly_sequencer.sv
// rtl/butterfly_sequencer.sv - in-place radix-2 FFT butterfly address/issue sequencer
// Ports: clk, rst (async, active-high), bus (butterfly_sequencer_if.master).
// Parameters: LOG2N (N = 2^LOG2N points, >= 2), BF_LATENCY (butterfly cycles, >= 1).
// Optional macro BUTTERFLY_SEQ_SCALE_EN: halve each result component on write-back.
module butterfly_sequencer #(
  parameter int LOG2N      = 3,
  parameter int BF_LATENCY = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  butterfly_sequencer_if.master  bus
);
  import butterfly_sequencer_pkg::*;

  localparam int N      = 1 << LOG2N;
  localparam int HALF_N = N / 2;
  localparam int PIPE   = 1 + BF_LATENCY;
  localparam int JW     = LOG2N - 1;
  localparam int SW     = (LOG2N > 1) ? $clog2(LOG2N) : 1;
  localparam int CW     = $clog2(PIPE);
  localparam int TAG_W  = 1 + 2 * LOG2N;

  function automatic logic [LOG2N-1:0] addr_a_of(input int unsigned j, input int unsigned s);
    return LOG2N'(((j >> s) << (s + 1)) + (j & ((32'd1 << s) - 1)));
  endfunction

  function automatic logic [LOG2N-1:0] addr_b_of(input int unsigned j, input int unsigned s);
    return LOG2N'(((j >> s) << (s + 1)) + (j & ((32'd1 << s) - 1)) + (32'd1 << s));
  endfunction

  function automatic logic [JW-1:0] tw_of(input int unsigned j, input int unsigned s);
    return JW'((j & ((32'd1 << s) - 1)) << (LOG2N - 1 - s));
  endfunction

  seq_state_t         state_q;
  logic [JW-1:0]      j_q;
  logic [SW-1:0]      s_q;
  logic [CW-1:0]      drain_q;
  logic               busy_q, done_q, rd_en_q;
  logic [LOG2N-1:0]   rd_addr_a_q, rd_addr_b_q;
  logic [JW-1:0]      tw_addr_q;

  // Index of the butterfly that would be issued on the next edge; addresses
  // are precomputed from it so the read request leaves a register.
  logic [JW-1:0]      cand_j;
  logic [SW-1:0]      cand_s;
  logic [LOG2N-1:0]   addr_a_n, addr_b_n;
  logic [JW-1:0]      tw_n;

  always_comb begin
    cand_j = '0;
    cand_s = '0;
    if (state_q == ISSUE) begin
      cand_j = j_q + 1'b1;
      cand_s = s_q;
    end else if (state_q == DRAIN) begin
      cand_s = s_q + 1'b1;
    end
    addr_a_n = addr_a_of(32'(cand_j), 32'(cand_s));
    addr_b_n = addr_b_of(32'(cand_j), 32'(cand_s));
    tw_n     = tw_of(32'(cand_j), 32'(cand_s));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      j_q         <= '0;
      s_q         <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // done_q is high in the completion cycle; a start seen then is dropped.
          if (bus.start && !done_q) begin
            state_q     <= ISSUE;
            j_q         <= '0;
            s_q         <= '0;
            busy_q      <= 1'b1;
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= addr_a_n;
            rd_addr_b_q <= addr_b_n;
            tw_addr_q   <= tw_n;
          end
        end
        ISSUE: begin
          if (j_q == JW'(HALF_N - 1)) begin
            state_q <= DRAIN;
            drain_q <= '0;
            rd_en_q <= 1'b0;
          end else begin
            j_q         <= cand_j;
            rd_addr_a_q <= addr_a_n;
            rd_addr_b_q <= addr_b_n;
            tw_addr_q   <= tw_n;
          end
        end
        DRAIN: begin
          // Wait out the full read+butterfly pipe so the next stage never
          // reads a location whose write-back is still in flight.
          if (drain_q == CW'(PIPE - 1)) begin
            if (s_q == SW'(LOG2N - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ISSUE;
              j_q         <= '0;
              s_q         <= cand_s;
              rd_en_q     <= 1'b1;
              rd_addr_a_q <= addr_a_n;
              rd_addr_b_q <= addr_b_n;
              tw_addr_q   <= tw_n;
            end
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [TAG_W-1:0] tag_out;

  seq_tag_delay #(
    .WIDTH (TAG_W),
    .DEPTH (PIPE)
  ) u_tag_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
    .dout (tag_out)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_addr   = tw_addr_q;

  assign bus.bf_a  = bus.rd_data_a;
  assign bus.bf_b  = bus.rd_data_b;
  assign bus.bf_tw = bus.tw_data;

  assign bus.wr_en     = tag_out[TAG_W-1];
  assign bus.wr_addr_a = tag_out[2*LOG2N-1:LOG2N];
  assign bus.wr_addr_b = tag_out[LOG2N-1:0];

`ifdef BUTTERFLY_SEQ_SCALE_EN
  assign bus.wr_data_a = scale_word(bus.bf_a_res);
  assign bus.wr_data_b = scale_word(bus.bf_b_res);
`else
  assign bus.wr_data_a = bus.bf_a_res;
  assign bus.wr_data_b = bus.bf_b_res;
`endif

endmodule

// File: tb/tb_butterfly_sequencer.sv
// tb/tb_butterfly_sequencer.sv - directed self-checking bench for butterfly_sequencer
module tb_butterfly_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  butterfly_sequencer_if #(.LOG2N(3)) bus();

  butterfly_sequencer #(
    .LOG2N      (3),
    .BF_LATENCY (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] RES_A = 64'h0000_0004_FFFF_FFFC;
  localparam logic [63:0] RES_B = 64'h8000_0002_0000_0003;
`ifdef BUTTERFLY_SEQ_SCALE_EN
  localparam logic [63:0] EXP_WA = 64'h0000_0002_FFFF_FFFE;
  localparam logic [63:0] EXP_WB = 64'hC000_0001_0000_0001;
`else
  localparam logic [63:0] EXP_WA = 64'h0000_0004_FFFF_FFFC;
  localparam logic [63:0] EXP_WB = 64'h8000_0002_0000_0003;
`endif

  // Hand-derived butterfly schedule: stage 0 j0..3, stage 1 j0..3, stage 2 j0..3.
  int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  // Memory and twiddle ROM models, 1-cycle latency, contents derived from address.
  always @(posedge clk) begin
    bus.rd_data_a <= {29'd0, bus.rd_addr_a, 16'd0, 13'h1400, bus.rd_addr_a};
    bus.rd_data_b <= {29'd0, bus.rd_addr_b, 16'd0, 13'h1400, bus.rd_addr_b};
    bus.tw_data   <= {16'h7000, 14'd0, bus.tw_addr};
  end

  logic       busy_l [64];
  logic       done_l [64];
  logic       rd_en_l[64];
  logic       wr_en_l[64];
  logic [2:0] ra_l [64], rb_l [64], wa_l [64], wb_l [64];
  logic [1:0] tw_l [64];
  logic [63:0] bfa_l [64], bfb_l [64], wda_l [64], wdb_l [64];
  logic [31:0] bft_l [64];

  task automatic sample(input int c);
    busy_l[c] = bus.busy;   done_l[c] = bus.done;
    rd_en_l[c] = bus.rd_en; wr_en_l[c] = bus.wr_en;
    ra_l[c] = bus.rd_addr_a; rb_l[c] = bus.rd_addr_b; tw_l[c] = bus.tw_addr;
    wa_l[c] = bus.wr_addr_a; wb_l[c] = bus.wr_addr_b;
    bfa_l[c] = bus.bf_a; bfb_l[c] = bus.bf_b; bft_l[c] = bus.bf_tw;
    wda_l[c] = bus.wr_data_a; wdb_l[c] = bus.wr_data_b;
  endtask

  // Raise start for cycle 0, record cycles 1..ncyc; start drops after cycle release_at is sampled.
  task automatic run_log(input int ncyc, input int release_at);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      sample(c);
      if (c == release_at) bus.start = 1'b0;
    end
  endtask

  function automatic int rd_slot(input int c);
    if (c >= 1 && c <= 4)   return c - 1;
    if (c >= 14 && c <= 17) return c - 14 + 4;
    if (c >= 27 && c <= 30) return c - 27 + 8;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.rd_en !== 1'b0)   begin bad++; $display("FAIL reset_rd_en got=%b want=0", bus.rd_en); end
    total++; if (bus.wr_en !== 1'b0)   begin bad++; $display("FAIL reset_wr_en got=%b want=0", bus.wr_en); end
    total++; if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== 8'd0)
      begin bad++; $display("FAIL reset_addr got=%h want=0", {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_run();
    int s;
    run_log(44, 1);
    for (int c = 1; c <= 44; c++) begin
      total++; if (busy_l[c] !== (c <= 39))
        begin bad++; $display("FAIL run_busy cyc=%0d got=%b want=%b", c, busy_l[c], c <= 39); end
      total++; if (done_l[c] !== (c == 40))
        begin bad++; $display("FAIL run_done cyc=%0d got=%b want=%b", c, done_l[c], c == 40); end
      s = rd_slot(c);
      total++; if (rd_en_l[c] !== (s >= 0))
        begin bad++; $display("FAIL run_rd_en cyc=%0d got=%b want=%b", c, rd_en_l[c], s >= 0); end
      if (s >= 0) begin
        total++; if (ra_l[c] !== 3'(exp_a[s]) || rb_l[c] !== 3'(exp_b[s]) || tw_l[c] !== 2'(exp_tw[s]))
          begin bad++; $display("FAIL run_rd_addr cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                                c, ra_l[c], rb_l[c], tw_l[c], exp_a[s], exp_b[s], exp_tw[s]); end
      end
      s = (c > 9) ? rd_slot(c - 9) : -1;
      total++; if (wr_en_l[c] !== (s >= 0))
        begin bad++; $display("FAIL run_wr_en cyc=%0d got=%b want=%b", c, wr_en_l[c], s >= 0); end
      if (s >= 0) begin
        total++; if (wa_l[c] !== 3'(exp_a[s]) || wb_l[c] !== 3'(exp_b[s]))
          begin bad++; $display("FAIL run_wr_addr cyc=%0d got=%0d/%0d want=%0d/%0d",
                                c, wa_l[c], wb_l[c], exp_a[s], exp_b[s]); end
      end
    end
    total++; if (bfa_l[2] !== 64'h0000_0000_0000_A000 || bfb_l[2] !== 64'h0000_0001_0000_A001)
      begin bad++; $display("FAIL bf_operands cyc=2 got=%h/%h want=0000_0000_0000_a000/0000_0001_0000_a001", bfa_l[2], bfb_l[2]); end
    total++; if (bft_l[2] !== 32'h7000_0000)
      begin bad++; $display("FAIL bf_tw cyc=2 got=%h want=70000000", bft_l[2]); end
    total++; if (bfa_l[16] !== 64'h0000_0001_0000_A001 || bfb_l[16] !== 64'h0000_0003_0000_A003)
      begin bad++; $display("FAIL bf_operands cyc=16 got=%h/%h want=0000_0001_0000_a001/0000_0003_0000_a003", bfa_l[16], bfb_l[16]); end
    total++; if (bft_l[16] !== 32'h7000_0002)
      begin bad++; $display("FAIL bf_tw cyc=16 got=%h want=70000002", bft_l[16]); end
    total++; if (wda_l[10] !== EXP_WA || wdb_l[10] !== EXP_WB)
      begin bad++; $display("FAIL wr_data cyc=10 got=%h/%h want=%h/%h", wda_l[10], wdb_l[10], EXP_WA, EXP_WB); end
  endtask

  task automatic test_start_held();
    int pulses = 0;
    run_log(41, 41);
    for (int c = 1; c <= 41; c++) if (done_l[c] === 1'b1) pulses++;
    total++; if (pulses !== 1) begin bad++; $display("FAIL held_done_pulses got=%0d want=1", pulses); end
    total++; if (done_l[40] !== 1'b1) begin bad++; $display("FAIL held_done_cyc40 got=%b want=1", done_l[40]); end
    total++; if (busy_l[39] !== 1'b1) begin bad++; $display("FAIL held_busy_cyc39 got=%b want=1", busy_l[39]); end
    total++; if (busy_l[41] !== 1'b0 || rd_en_l[41] !== 1'b0)
      begin bad++; $display("FAIL held_no_restart cyc=41 busy=%b rd_en=%b want=0/0", busy_l[41], rd_en_l[41]); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL held_idle_after got=%b want=0", bus.busy); end
  endtask

  task automatic test_reset_mid_run();
    int wr_seen = 0;
    int busy_seen = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if ({bus.busy, bus.done, bus.rd_en, bus.wr_en} !== 4'b0000)
      begin bad++; $display("FAIL mid_rst_ctrl got=%b want=0000", {bus.busy, bus.done, bus.rd_en, bus.wr_en}); end
    total++; if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b} !== 14'd0)
      begin bad++; $display("FAIL mid_rst_addr got=%h want=0", {bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr, bus.wr_addr_a, bus.wr_addr_b}); end
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (bus.wr_en === 1'b1) wr_seen++;
      if (bus.busy === 1'b1) busy_seen++;
    end
    total++; if (wr_seen !== 0) begin bad++; $display("FAIL mid_rst_stray_wr got=%0d want=0", wr_seen); end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL mid_rst_stray_busy got=%0d want=0", busy_seen); end
    run_log(42, 1);
    total++; if (busy_l[1] !== 1'b1 || busy_l[39] !== 1'b1 || busy_l[40] !== 1'b0)
      begin bad++; $display("FAIL rerun_busy got=%b%b%b want=110", busy_l[1], busy_l[39], busy_l[40]); end
    total++; if (done_l[39] !== 1'b0 || done_l[40] !== 1'b1 || done_l[41] !== 1'b0)
      begin bad++; $display("FAIL rerun_done got=%b%b%b want=010", done_l[39], done_l[40], done_l[41]); end
    total++; if (wr_en_l[10] !== 1'b1 || wa_l[10] !== 3'd0 || wb_l[10] !== 3'd1 || wr_en_l[9] !== 1'b0)
      begin bad++; $display("FAIL rerun_first_wr got=%b/%0d/%0d pre=%b want=1/0/1 pre=0", wr_en_l[10], wa_l[10], wb_l[10], wr_en_l[9]); end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.bf_a_res  = RES_A;
    bus.bf_b_res  = RES_B;
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    bus.tw_data   = '0;
    rst           = 1'b0;
    test_reset();
    test_full_run();
    test_start_held();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/butterfly_sequencer.md
BUTTERFLY_SEQUENCER -- requirements
Module: butterfly_sequencer

Interface
REQ-001 SHALL have parameter LOG2N, default 3, meaning log2 of FFT points (N = 2^LOG2N).
REQ-002 SHALL have parameter BF_LATENCY, default 8, meaning butterfly input-to-output latency in cycles.
REQ-003 clk  input  1  clock, all state rising-edge.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 start  input  1  begin in-place FFT pass over data memory.
REQ-006 busy  output  1  high from accepted start until done.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 rd_en, rd_addr_a, rd_addr_b  output  1, LOG2N, LOG2N  data memory read request.
REQ-009 rd_data_a, rd_data_b  input  64 each  read data, 1-cycle latency; {real[63:32], imag[31:0]}.
REQ-010 tw_addr  output  LOG2N-1  twiddle ROM index; tw_data input 32, 1-cycle latency, {real Q15, imag Q15}.
REQ-011 bf_a, bf_b  output  64 each; bf_tw output 32  butterfly operands.
REQ-012 bf_a_res, bf_b_res  input  64 each  butterfly results.
REQ-013 wr_en, wr_addr_a, wr_addr_b  output  1, LOG2N, LOG2N; wr_data_a, wr_data_b output 64 each  write-back.

Function
REQ-014 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> (ISSUE next stage | IDLE); start sampled only in IDLE, ignored otherwise.
REQ-015 ISSUE: one butterfly per cycle, index j = 0..N/2-1, stage s = 0..LOG2N-1, rd_en=1.
REQ-016 Addressing: half=2^s, k=j mod half, rd_addr_a=(j>>s)*2*half+k, rd_addr_b=rd_addr_a+half, tw_addr=k<<(LOG2N-1-s).
REQ-017 bf_a=rd_data_a, bf_b=rd_data_b, bf_tw=tw_data, combinational.
REQ-018 SHALL carry valid and both addresses through a delay line of depth PIPE=1+BF_LATENCY.
REQ-019 wr_en SHALL assert exactly PIPE cycles after the matching rd_en cycle, with delayed addresses; wr_data_* = bf_*_res (see REQ-027).
REQ-020 DRAIN SHALL last exactly PIPE cycles so the last write of stage s precedes the first read of stage s+1 (no RAW hazard).
REQ-021 After final stage DRAIN: done=1 for one cycle, busy=0, return to IDLE.
REQ-022 Cycle count: start sampled in cycle 0 -> done in cycle 1 + LOG2N*(N/2+PIPE).
REQ-023 start asserted in the same cycle done pulses SHALL be ignored.

Reset
REQ-024 rst SHALL force IDLE, j=0, s=0, clear delay-line valid bits; busy, done, rd_en, wr_en = 0; addresses and tw_addr = 0.
REQ-025 rst mid-operation SHALL abort; no wr_en after rst deasserts until a new start.

Configuration
REQ-026 Macro BUTTERFLY_SEQ_SCALE_EN selects per-stage scaling.
REQ-027 Defined: each 32-bit component of wr_data_* = arithmetic right shift by 1 of bf_*_res component; undefined: wr_data_* = bf_*_res unchanged.

Structure
REQ-028 Shared package SHALL hold FSM state typedef (IDLE, ISSUE, DRAIN) and the 64-bit complex-word field constants (REAL_MSB=63, IMAG_MSB=31).
REQ-029 Delay line SHALL be a sub-module, seq_tag_delay (width, depth parameters, async clear).

Verification
REQ-030 LOG2N=3, BF_LATENCY=8, start at cycle 0 -> busy 1..39, done=1 in cycle 40 only.
REQ-031 Stage 0, j=0 -> rd_addr_a=0, rd_addr_b=1, tw_addr=0; stage 1, j=1 -> 1, 3, tw 2; stage 2, j=3 -> 3, 7, tw 3.
REQ-032 rd_en in cycle 1 (addr 0/1) -> wr_en in cycle 10 with wr_addr_a=0, wr_addr_b=1; no wr_en in cycles 14..17 overlaps stage-1 reads of pending addresses.
REQ-033 bf_a_res=0x0000_0004_FFFF_FFFC with BUTTERFLY_SEQ_SCALE_EN -> wr_data_a=0x0000_0002_FFFF_FFFE; without -> unchanged.
REQ-034 rst pulsed in cycle 20 -> all outputs 0 next cycle, no wr_en until new start; start re-accepted and full 40-cycle run completes.
REQ-035 start held high through run -> exactly one done pulse, no restart within same run.
